spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 197 +++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronizes SCK/MOSI/DC/CS into the clk domain, shifts
// 8-bit words MSB first tagged with the DC flag, and hands them to a consumer
// through a valid/ready interface.
// Optional feature: define SPI_SLAVE_RX_FIFO_EN for a FIFO_DEPTH-entry receive
// FIFO; otherwise a single holding register is used.
module spi_slave_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_sck,
   input  logic       spi_mosi,
   input  logic       spi_dc,
   input  logic       spi_cs,
   output logic [8:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy
);

   // Catch illegal configurations at elaboration time.
   if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $fatal(1, "spi_slave_rx: illegal SYNC_STAGES or FIFO_DEPTH");
   end

   typedef enum logic {StIdle, StShift} state_e;

   logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q, dc_sync_q;
   logic                   sck_s, cs_s, mosi_s, dc_s;
   logic                   sck_prev_q, cs_prev_q;
   logic                   sck_rise, cs_rise, cs_fall;

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic       push;
   logic [8:0] push_data;
   logic       frame_err_d;
   logic       frame_err_q, overrun_q;
   logic       pop, full;

   // Input synchronizers, reset to the bus idle levels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync_q  <= '1;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         dc_sync_q   <= '0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
      end
   end

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign dc_s   = dc_sync_q[SYNC_STAGES-1];

   // Previous synchronized levels for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_prev_q <= 1'b1;
         cs_prev_q  <= 1'b1;
      end else begin
         sck_prev_q <= sck_s;
         cs_prev_q  <= cs_s;
      end
   end

   assign sck_rise = sck_s & ~sck_prev_q;
   assign cs_fall  = ~cs_s & cs_prev_q;
   assign cs_rise  = cs_s & ~cs_prev_q;

   // FSM, bit counter and shift register state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 3'd0;
         shreg_q     <= 8'h00;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next-state logic; a word completes on the edge that wraps the counter.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      push        = 1'b0;
      push_data   = {dc_s, shreg_q[6:0], mosi_s};
      frame_err_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cs_fall) begin
               state_d = StShift;
               cnt_d   = 3'd0;
               shreg_d = 8'h00;
            end
         end
         StShift: begin
            if (cs_rise) begin
               // Any partially shifted word is dropped here.
               state_d     = StIdle;
               frame_err_d = (cnt_q != 3'd0);
               cnt_d       = 3'd0;
               shreg_d     = 8'h00;
            end else if (sck_rise) begin
               shreg_d = {shreg_q[6:0], mosi_s};
               cnt_d   = cnt_q + 3'd1;
               push    = (cnt_q == 3'd7);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy = (state_q == StShift);
   assign pop  = rx_valid & rx_ready;

`ifdef SPI_SLAVE_RX_FIFO_EN
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [8:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          wr_en;

   assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
   assign wr_en = push & (~full | pop);

   // Receive FIFO; pointers wrap naturally because the depth is a power of 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 9'h000;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rx_data  = mem_q[rd_ptr_q];
   assign rx_valid = (count_q != '0);
`else
   logic [8:0] hold_q;
   logic       valid_q;

   assign full = valid_q;

   // Single holding register; a pop frees the slot for a same-cycle push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q  <= 9'h000;
         valid_q <= 1'b0;
      end else if (push && (!full || pop)) begin
         hold_q  <= push_data;
         valid_q <= 1'b1;
      end else if (pop) begin
         valid_q <= 1'b0;
      end
   end

   assign rx_data  = hold_q;
   assign rx_valid = valid_q;
`endif

   // Overrun pulse: completed word dropped because storage stayed full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) overrun_q <= 1'b0;
      else     overrun_q <= push & full & ~pop;
   end

   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: directed scenarios plus randomized
// frames, checked against a word-level storage model.
module tb_spi_slave_rx;

`ifdef SPI_SLAVE_RX_FIFO_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 1;
`endif

   logic       clk = 1'b0;
   logic       rst, sck, mosi, dc, cs, rx_ready;
   logic [8:0] rx_data;
   logic       rx_valid, overrun, frame_err, busy;

   spi_slave_rx #(.SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .spi_sck   (sck),
      .spi_mosi  (mosi),
      .spi_dc    (dc),
      .spi_cs    (cs),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .overrun   (overrun),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Monitor on the falling edge: inputs only change just after rising edges.
   logic [8:0] got[$];
   int ovr_n = 0, ferr_n = 0, vcyc_n = 0, busy_low_n = 0;
   bit busy_watch = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) got.push_back(rx_data);
         if (overrun) ovr_n++;
         if (frame_err) ferr_n++;
         if (rx_valid) vcyc_n++;
         if (busy_watch && !busy) busy_low_n++;
      end
   end

   // Reference model: words expected at the consumer plus storage occupancy.
   logic [8:0] exp_q[$];
   int occ = 0;
   int exp_ovr = 0;
   int got_base = 0;

   function automatic void model_push(input logic [8:0] w);
      if (occ < CAP) begin
         exp_q.push_back(w);
         occ++;
      end else begin
         exp_ovr++;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // SCK half period of 4 clk cycles; data changes while SCK is low.
   // pop_last raises rx_ready for exactly the cycle the final bit is pushed.
   task automatic send_bits(input logic [7:0] b, input logic d, input int nbits,
                            input bit pop_last);
      for (int i = 0; i < nbits; i++) begin
         sck  = 1'b0;
         mosi = b[7-i];
         dc   = d;
         tick(4);
         sck = 1'b1;
         if (pop_last && i == nbits - 1) begin
            tick(2);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            tick(1);
         end else begin
            tick(4);
         end
      end
   endtask

   task automatic send_word(input logic [7:0] b, input logic d);
      send_bits(b, d, 8, 1'b0);
   endtask

   task automatic cs_low();
      cs = 1'b0;
      tick(4);
   endtask

   task automatic cs_high();
      tick(2);
      cs = 1'b1;
      tick(8);
   endtask

   // Compare everything delivered since the last call against the model queue.
   task automatic check_words(input string tag);
      int n;
      n = got.size() - got_base;
      chk({tag, "_count"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n; i++)
         chk({tag, "_word"}, 32'(got[got_base + i]), 32'(exp_q[i]));
      got_base = got.size();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rx_data"}, 32'(rx_data), 32'h000);
      chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
      chk({tag, "_overrun"}, 32'(overrun), 32'd0);
      chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int v0, f0, o0, b0, nw, nb;
      logic [7:0] w;
      logic       d;
      logic [8:0] t5_words[$];

      rst = 1'b1; sck = 1'b1; cs = 1'b1; mosi = 1'b0; dc = 1'b0; rx_ready = 1'b0;
      tick(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick(3);

      // Single word, consumer always ready.
      rx_ready = 1'b1;
      v0 = vcyc_n; f0 = ferr_n; o0 = ovr_n;
      cs_low();
      send_word(8'hA5, 1'b1);
      cs_high();
      exp_q.push_back(9'h1A5);
      check_words("single");
      chk("single_valid_cycles", vcyc_n - v0, 1);
      chk("single_frame_err", ferr_n - f0, 0);
      chk("single_overrun", ovr_n - o0, 0);

      // Back-to-back words under one CS assertion.
      b0 = busy_low_n;
      cs_low();
      busy_watch = 1'b1;
      send_word(8'h2A, 1'b0);
      send_word(8'h11, 1'b1);
      busy_watch = 1'b0;
      cs_high();
      exp_q.push_back(9'h02A);
      exp_q.push_back(9'h111);
      check_words("b2b");
      chk("b2b_busy_low", busy_low_n - b0, 0);
      chk("b2b_idle_busy", 32'(busy), 0);

      // Aborted frame after 5 bits, then a good one.
      f0 = ferr_n;
      cs_low();
      send_bits(8'hB7, 1'b1, 5, 1'b0);
      cs_high();
      cs_low();
      send_word(8'h3C, 1'b0);
      cs_high();
      exp_q.push_back(9'h03C);
      check_words("abort");
      chk("abort_frame_err", ferr_n - f0, 1);

      // Five words with the consumer stalled.
      rx_ready = 1'b0;
      o0 = ovr_n; occ = 0; exp_ovr = 0;
      cs_low();
      for (int k = 0; k < 5; k++) begin
         w = 8'($urandom);
         d = 1'($urandom);
         send_word(w, d);
         model_push({d, w});
      end
      cs_high();
      chk("stall_overrun", ovr_n - o0, exp_ovr);
      chk("stall_valid", 32'(rx_valid), 1);
      rx_ready = 1'b1;
      tick(20);
      occ = 0;
      check_words("stall");

      // Storage full, pop coincides with the push of one more word.
      rx_ready = 1'b0;
      o0 = ovr_n;
      cs_low();
      for (int k = 0; k <= CAP; k++) begin
         w = 8'($urandom);
         d = 1'($urandom);
         send_bits(w, d, 8, k == CAP);
         t5_words.push_back({d, w});
      end
      cs_high();
      chk("fullpop_overrun", ovr_n - o0, 0);
      chk("fullpop_valid", 32'(rx_valid), 1);
      chk("fullpop_popped", got.size() - got_base, 1);
      rx_ready = 1'b1;
      tick(20);
      foreach (t5_words[i]) exp_q.push_back(t5_words[i]);
      check_words("fullpop");

      // Reset mid-word, then a fresh frame.
      f0 = ferr_n;
      cs_low();
      send_bits(8'h55, 1'b0, 3, 1'b0);
      rst = 1'b1;
      tick(1);
      check_reset_outputs("midrst");
      cs = 1'b1;
      sck = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(4);
      cs_low();
      send_word(8'hFF, 1'b1);
      cs_high();
      exp_q.push_back(9'h1FF);
      check_words("midrst");
      chk("midrst_frame_err", ferr_n - f0, 0);

      // Randomized frames with optional trailing partial word.
      f0 = ferr_n; o0 = ovr_n;
      v0 = 0;
      rx_ready = 1'b1;
      for (int f = 0; f < 12; f++) begin
         cs_low();
         nw = $urandom_range(1, 3);
         for (int k = 0; k < nw; k++) begin
            w = 8'($urandom);
            d = 1'($urandom);
            send_word(w, d);
            exp_q.push_back({d, w});
         end
         nb = $urandom_range(0, 7);
         if (nb != 0) begin
            send_bits(8'($urandom), 1'($urandom), nb, 1'b0);
            v0++;
         end
         cs_high();
      end
      check_words("rand");
      chk("rand_frame_err", ferr_n - f0, v0);
      chk("rand_overrun", ovr_n - o0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
